// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM encoding and sizing helper for alu_seq and alu_mul_iter.
// Codes 0-7 keep the legacy 3-bit ALU meanings.
package alu_seq_pkg;

  localparam int OP_HLT = 0;
  localparam int OP_SKZ = 1;
  localparam int OP_ADD = 2;
  localparam int OP_AND = 3;
  localparam int OP_XOR = 4;
  localparam int OP_LDA = 5;
  localparam int OP_STO = 6;
  localparam int OP_JMP = 7;
  localparam int OP_SUB = 8;
  localparam int OP_OR  = 9;
  localparam int OP_SHL = 10;
  localparam int OP_SHR = 11;
  localparam int OP_MUL = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to hold a step count of 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative WIDTH-step unsigned shift-add multiplier used by alu_seq when
// ALU_SEQ_MUL_EN is defined.
module alu_mul_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int CW = cnt_w(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_part;
  logic [WIDTH-1:0]   r_mplr;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_part_nxt;

  assign w_part_nxt = r_mplr[0] ? (r_part + r_mcand) : r_part;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_part  <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
    end else if (start) begin
      r_mcand <= {{WIDTH{1'b0}}, a};
      r_part  <= '0;
      r_mplr  <= b;
      r_cnt   <= CW'(WIDTH);
    end else if (busy) begin
      r_part  <= w_part_nxt;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  assign busy = (r_cnt != '0);
  // done marks the cycle of the final step; prod is the full product only then,
  // so the consumer captures it on the same edge the last step retires.
  assign done = (r_cnt == CW'(1));
  assign prod = w_part_nxt;

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked ALU with Z/C/N/V flags.
// Define ALU_SEQ_MUL_EN to build the multi-cycle MUL (opcode 12); otherwise MUL passes acc.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcd,
  input  logic [WIDTH-1:0] acc_out,
  input  logic [WIDTH-1:0] mdat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zr,
  output logic             cy,
  output logic             ng,
  output logic             ov
);

  localparam int M = WIDTH - 1;
  localparam logic [OPW-1:0] C_ADD = OPW'(OP_ADD);
  localparam logic [OPW-1:0] C_AND = OPW'(OP_AND);
  localparam logic [OPW-1:0] C_XOR = OPW'(OP_XOR);
  localparam logic [OPW-1:0] C_LDA = OPW'(OP_LDA);
  localparam logic [OPW-1:0] C_SUB = OPW'(OP_SUB);
  localparam logic [OPW-1:0] C_OR  = OPW'(OP_OR);
  localparam logic [OPW-1:0] C_SHL = OPW'(OP_SHL);
  localparam logic [OPW-1:0] C_SHR = OPW'(OP_SHR);
`ifdef ALU_SEQ_MUL_EN
  localparam logic [OPW-1:0] C_MUL = OPW'(OP_MUL);
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_res;
  logic             r_cy;
  logic             r_ov;

  logic             w_fire;
  logic             w_is_mul;
  logic             w_ld_alu;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_cy;
  logic             w_ov;

`ifdef ALU_SEQ_MUL_EN
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic               w_ld_mul;
  logic [2*WIDTH-1:0] w_prod;
`endif

  assign w_fire = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  assign w_is_mul    = (opcd == C_MUL);
  assign w_mul_start = w_fire && w_is_mul;
  assign w_ld_mul    = (r_state == ST_BUSY) && w_mul_done;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_mul_start),
    .a     (acc_out),
    .b     (mdat),
    .busy  (w_mul_busy),
    .done  (w_mul_done),
    .prod  (w_prod)
  );
`else
  assign w_is_mul = 1'b0;
`endif

  assign w_ld_alu = w_fire && !w_is_mul;

  // Single-cycle datapath evaluated straight from the request so the result
  // lands in r_res on the acceptance edge.
  assign w_sum = {1'b0, acc_out} + {1'b0, mdat};
  assign w_dif = {1'b0, acc_out} - {1'b0, mdat};

  always_comb begin
    w_res = acc_out;
    w_cy  = 1'b0;
    w_ov  = 1'b0;
    case (opcd)
      C_ADD: begin
        w_res = w_sum[M:0];
        w_cy  = w_sum[WIDTH];
        w_ov  = (acc_out[M] == mdat[M]) && (w_sum[M] != acc_out[M]);
      end
      C_SUB: begin
        w_res = w_dif[M:0];
        w_cy  = w_dif[WIDTH];
        w_ov  = (acc_out[M] != mdat[M]) && (w_dif[M] != acc_out[M]);
      end
      C_AND: w_res = acc_out & mdat;
      C_XOR: w_res = acc_out ^ mdat;
      C_OR:  w_res = acc_out | mdat;
      C_LDA: w_res = mdat;
      C_SHL: begin
        w_res = {acc_out[M-1:0], 1'b0};
        w_cy  = acc_out[M];
      end
      C_SHR: begin
        w_res = {1'b0, acc_out[M:1]};
        w_cy  = acc_out[0];
      end
      default: w_res = acc_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // DONE behaves like IDLE when the consumer drains this cycle, so a new
  // request can follow with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_fire)                                w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
        else if (r_state == ST_DONE && out_ready)  w_state_nxt = ST_IDLE;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_BUSY: begin
        if (w_mul_done)       w_state_nxt = ST_DONE;
        else if (!w_mul_busy) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_cy  <= 1'b0;
      r_ov  <= 1'b0;
    end else if (w_ld_alu) begin
      r_res <= w_res;
      r_cy  <= w_cy;
      r_ov  <= w_ov;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (w_ld_mul) begin
      r_res <= w_prod[M:0];
      r_cy  <= |w_prod[2*WIDTH-1:WIDTH];
      r_ov  <= 1'b0;
    end
`endif
  end

  assign alu_out = r_res;
  assign cy      = r_cy;
  assign ov      = r_ov;
  assign zr      = (r_res == '0);
  assign ng      = r_res[M];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, hand sequences for
// back-to-back, backpressure and mid-operation reset, then randomized traffic.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int MOD  = 256;
  localparam int HALF = 128;
`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_LAT  = W + 1;
  localparam int MUL_BUSY = W;
  localparam bit MUL_ON   = 1'b1;
`else
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
  localparam bit MUL_ON   = 1'b0;
`endif
  localparam int NRAND = 300;

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [3:0]   opcd;
  logic [W-1:0] acc_out, mdat;
  logic         out_valid, out_ready;
  logic [W-1:0] alu_out;
  logic         zr, cy, ng, ov;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cy;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         cy;
    logic         ov;
  } exp_t;

  alu_seq #(.WIDTH(W), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcd      (opcd),
    .acc_out   (acc_out),
    .mdat      (mdat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .zr        (zr),
    .cy        (cy),
    .ng        (ng),
    .ov        (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions, not the gate structure.
  function automatic exp_t ref_op(input int op, input int a, input int b);
    exp_t e;
    int r, sa, sb, s;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    e.cy = 1'b0;
    e.ov = 1'b0;
    r = a;
    case (op)
      2: begin r = a + b; e.cy = (r >= MOD); s = sa + sb; e.ov = (s >= HALF) || (s < -HALF); end
      8: begin r = a - b; e.cy = (a < b);    s = sa - sb; e.ov = (s >= HALF) || (s < -HALF); end
      3: r = a & b;
      4: r = a ^ b;
      9: r = a | b;
      5: r = b;
      10: begin r = a * 2; e.cy = (a >= HALF); end
      11: begin r = a / 2; e.cy = (a % 2 == 1); end
      12: if (MUL_ON) begin r = a * b; e.cy = (r >= MOD); end
      default: r = a;
    endcase
    e.res = W'(r);
    return e;
  endfunction

  // One isolated transaction with out_ready held high; checks latency, busy span and flags.
  task automatic run_one(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er,
                         input logic ecy, input logic eov);
    int lat, bsy, wt;
    wt = 0;
    opcd = op; acc_out = a; mdat = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    while (!in_ready && wt < 50) begin @(posedge clk); #1; wt++; end
    chk({nm, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; opcd = 4'($urandom); acc_out = W'($urandom); mdat = W'($urandom);
    lat = 1; bsy = 0;
    while (!out_valid && lat < 50) begin
      if (!in_ready) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"},  32'(lat), (op == 4'd12) ? 32'(MUL_LAT) : 32'd1);
    chk({nm, "_busy"}, 32'(bsy), (op == 4'd12) ? 32'(MUL_BUSY) : 32'd0);
    chk({nm, "_res"},  32'(alu_out), 32'(er));
    chk({nm, "_cy"},   32'(cy), 32'(ecy));
    chk({nm, "_ov"},   32'(ov), 32'(eov));
    chk({nm, "_zr"},   32'(zr), 32'(er == '0));
    chk({nm, "_ng"},   32'(ng), 32'(er[W-1]));
    @(posedge clk); #1;
  endtask

  vec_t vt[15];
  vec_t bb[4];

  initial begin
    vt[0]  = '{4'd2,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    vt[1]  = '{4'd8,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vt[2]  = '{4'd8,  8'h05, 8'h05, 8'h00, 1'b0, 1'b0};
    vt[3]  = '{4'd11, 8'h03, 8'h77, 8'h01, 1'b1, 1'b0};
    vt[4]  = '{4'd10, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};
    vt[5]  = '{4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    vt[6]  = '{4'd4,  8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0};
    vt[7]  = '{4'd9,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
    vt[8]  = '{4'd5,  8'h12, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vt[9]  = '{4'd7,  8'h5A, 8'h11, 8'h5A, 1'b0, 1'b0};
    vt[10] = '{4'd14, 8'h80, 8'h01, 8'h80, 1'b0, 1'b0};
    vt[11] = '{4'd2,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vt[12] = '{4'd8,  8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vt[13] = '{4'd0,  8'h33, 8'h44, 8'h33, 1'b0, 1'b0};
    vt[14] = '{4'd12, 8'h10, 8'h11, 8'h10, MUL_ON, 1'b0};

    bb[0] = '{4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    bb[1] = '{4'd4,  8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0};
    bb[2] = '{4'd5,  8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0};
    bb[3] = '{4'd11, 8'h03, 8'h00, 8'h01, 1'b1, 1'b0};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcd = '0; acc_out = '0; mdat = '0;

    // Reset values.
    #3 rst_n = 1'b0;
    #4;
    chk("rst_alu_out",   32'(alu_out),   32'd0);
    chk("rst_zr",        32'(zr),        32'd1);
    chk("rst_cy",        32'(cy),        32'd0);
    chk("rst_ng",        32'(ng),        32'd0);
    chk("rst_ov",        32'(ov),        32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 15; i++)
      run_one($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].cy, vt[i].ov);

    // Back-to-back single-cycle ops: one result per cycle, in_ready stays high.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcd = bb[i].op; acc_out = bb[i].a; mdat = bb[i].b; in_valid = 1'b1;
      #1;
      chk($sformatf("b2b%0d_rdy", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_vld", i), 32'(out_valid), 32'd1);
      chk($sformatf("b2b%0d_res", i), 32'(alu_out),   32'(bb[i].res));
      chk($sformatf("b2b%0d_cy", i),  32'(cy),        32'(bb[i].cy));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // Backpressure: result held, new request ignored, then drain + accept together.
    out_ready = 1'b0;
    opcd = 4'd2; acc_out = 8'h01; mdat = 8'h02; in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    opcd = 4'd4; acc_out = 8'hFF; mdat = 8'hFF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_vld", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_res", i), 32'(alu_out),   32'h03);
      chk($sformatf("bp%0d_zr", i),  32'(zr),        32'd0);
      chk($sformatf("bp%0d_rdy", i), 32'(in_ready),  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_next_vld", 32'(out_valid), 32'd1);
    chk("bp_next_res", 32'(alu_out),   32'h00);
    chk("bp_next_zr",  32'(zr),        32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Reset in the 4th busy cycle (MUL) or 4th stalled cycle (no multiplier).
    run_one("pre", 4'd5, 8'h00, 8'h99, 8'h99, 1'b0, 1'b0);
    if (MUL_ON) begin opcd = 4'd12; acc_out = 8'h10; mdat = 8'h11; end
    else        begin opcd = 4'd2;  acc_out = 8'h40; mdat = 8'h41; end
    out_ready = 1'b0; in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    if (MUL_ON) chk("mid_busy_rdy",  32'(in_ready), 32'd0);
    else        chk("mid_stall_res", 32'(alu_out),  32'h81);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_out",   32'(alu_out),   32'd0);
    chk("mid_rst_zr",        32'(zr),        32'd1);
    chk("mid_rst_cy",        32'(cy),        32'd0);
    chk("mid_rst_ng",        32'(ng),        32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int nv;
      nv = 0;
      repeat (12) begin
        if (out_valid) nv++;
        @(posedge clk); #1;
      end
      chk("mid_rst_no_valid", 32'(nv), 32'd0);
    end
    run_one("post_add", 4'd2, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    // Randomized traffic with random backpressure against the reference model.
    begin
      exp_t q[$];
      exp_t e;
      int issued, got, cyc;
      logic fire;
      issued = 0; got = 0; cyc = 0;
      in_valid = 1'b0;
      while (got < NRAND && cyc < 20000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid && issued < NRAND && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          opcd = 4'($urandom_range(0, 15));
          acc_out = W'($urandom); mdat = W'($urandom);
        end else if (!in_valid) begin
          acc_out = W'($urandom); mdat = W'($urandom);
        end
        #1;
        if (out_valid && out_ready) begin
          chk("rnd_q_nonempty", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("rnd%0d_res", got), 32'(alu_out), 32'(e.res));
            chk($sformatf("rnd%0d_cy", got),  32'(cy),      32'(e.cy));
            chk($sformatf("rnd%0d_ov", got),  32'(ov),      32'(e.ov));
            chk($sformatf("rnd%0d_zr", got),  32'(zr),      32'(e.res == '0));
            chk($sformatf("rnd%0d_ng", got),  32'(ng),      32'(e.res[W-1]));
            got++;
          end
        end
        fire = in_valid && in_ready;
        if (fire) begin
          q.push_back(ref_op(int'(opcd), int'(acc_out), int'(mdat)));
          issued++;
        end
        @(posedge clk); #1;
        cyc++;
        if (fire) in_valid = 1'b0;
      end
      chk("rnd_count",    32'(got),      32'(NRAND));
      chk("rnd_q_empty",  32'(q.size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
